// File: rtl/row_max_sub_pkg.sv
// rtl/row_max_sub_pkg.sv - shared FSM type, output width selection and saturation helper
//
// Purpose : types and helpers shared by row_max_sub and row_buf_ram.
// Macro   : ROW_MAX_SUB_SAT_EN selects a D_W-wide saturated output instead of
//           the exact D_W+1-wide difference.
package row_max_sub_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Output width is D_W + OUT_W_EXTRA.
`ifdef ROW_MAX_SUB_SAT_EN
  localparam int OUT_W_EXTRA = 0;
`else
  localparam int OUT_W_EXTRA = 1;
`endif

  // Clamp a signed value to the most negative dw-bit number. Only the low
  // side is needed: (x - row_max) is never positive.
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] lo;
    lo = -(64'sd1 <<< (dw - 1));
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/row_buf_ram.sv
// rtl/row_buf_ram.sv - simple dual-port row buffer with registered read
//
// Purpose : holds one row of scores. One write port, one read port, read data
//           registered and held while rd_en is low. A read of the address being
//           written in the same cycle returns the old contents.
// Ports   : clk              clock
//           wr_en/addr/data  write port
//           rd_en/addr       read request, data appears on rd_data next cycle
//           rd_data          registered read data
module row_buf_ram
  import row_max_sub_pkg::*;
#(
  parameter int D_W    = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [D_W-1:0]    wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [D_W-1:0]    rd_data
);

  logic [D_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/row_max_sub.sv
// rtl/row_max_sub.sv - buffers a score row, tracks its max, replays x - row_max
//
// Purpose : softmax front end. FILL accepts one row into the buffer while
//           tracking the signed maximum; DRAIN replays the row as x - row_max.
// Macro   : ROW_MAX_SUB_SAT_EN -> out_data is D_W bits, saturated low.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           in_valid/ready/data/last input stream (ready only in FILL)
//           out_valid/ready/data/last output stream
//           row_max                  max of the current / last row
//           err_overflow             sticky, set when a row hits MAX_LEN without in_last
module row_max_sub
  import row_max_sub_pkg::*;
#(
  parameter int D_W     = 32,
  parameter int MAX_LEN = 128,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [D_W-1:0]             in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [D_W+OUT_W_EXTRA-1:0] out_data,
  output logic                       out_last,
  output logic [D_W-1:0]             row_max,
  output logic                       err_overflow
);

  localparam int OUT_W = D_W + OUT_W_EXTRA;

  state_e            state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] last_idx;   // index of the final element (len - 1)
  logic [ADDR_W:0]   rd_ptr;     // next address to read; one extra bit to pass last_idx

  // Prefetch stage: RAM output register, or bypass data for a one-element row
  logic              s1_valid;
  logic              s1_last;
  logic              s1_byp;
  logic [D_W-1:0]    byp_data;
  logic [D_W-1:0]    rd_data;
  logic [D_W-1:0]    s1_data;

  logic              in_fire;
  logic              first_beat;
  logic              at_max;
  logic              row_end;
  logic              forced_end;
  logic              out_free;
  logic              s1_move;
  logic              more;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic signed [D_W:0] diff;
  logic [OUT_W-1:0]  out_next;

  assign in_ready   = (state == FILL);
  assign in_fire    = in_valid && in_ready;
  assign first_beat = (count == '0);
  assign at_max     = (count == ADDR_W'(MAX_LEN - 1));
  assign row_end    = in_fire && (in_last || at_max);
  assign forced_end = in_fire && !in_last && at_max;

  assign out_free = !out_valid || out_ready;
  assign s1_move  = s1_valid && out_free;
  assign more     = ({1'b0, last_idx} >= rd_ptr);

  // Element 0 is requested on the row-ending beat so the first result is ready
  // one cycle into DRAIN. If element 0 is being written on that same beat the
  // RAM returns stale data, so s1_byp substitutes the incoming value instead.
  assign rd_en   = row_end || ((state == DRAIN) && more && (!s1_valid || s1_move));
  assign rd_addr = (state == FILL) ? '0 : rd_ptr[ADDR_W-1:0];
  assign s1_data = s1_byp ? byp_data : rd_data;

  // Both operands sign-extended by one bit, so the difference is exact.
  assign diff = $signed({s1_data[D_W-1], s1_data}) - $signed({row_max[D_W-1], row_max});

  always_comb begin
    out_next = '0;
`ifdef ROW_MAX_SUB_SAT_EN
    out_next = OUT_W'(sat_to_dw(64'(diff), D_W));
`else
    out_next = OUT_W'(diff);
`endif
  end

  row_buf_ram #(
    .D_W   (D_W),
    .DEPTH (MAX_LEN),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_addr(count),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      count        <= '0;
      last_idx     <= '0;
      rd_ptr       <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s1_byp       <= 1'b0;
      byp_data     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      row_max      <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (in_fire) begin
        count <= count + 1'b1;
        if (first_beat || ($signed(in_data) > $signed(row_max)))
          row_max <= in_data;
      end

      if (forced_end) err_overflow <= 1'b1;

      if (row_end) begin
        state    <= DRAIN;
        last_idx <= count;
        rd_ptr   <= (ADDR_W + 1)'(1);
        s1_valid <= 1'b1;
        s1_last  <= first_beat;
        s1_byp   <= first_beat;
        byp_data <= in_data;
      end else if (rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        s1_valid <= 1'b1;
        s1_last  <= (rd_ptr[ADDR_W-1:0] == last_idx);
        s1_byp   <= 1'b0;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end

      // Output register only loads when empty or being consumed, so it holds
      // stable across stalls.
      if (s1_move) begin
        out_valid <= 1'b1;
        out_data  <= out_next;
        out_last  <= s1_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready && out_last) begin
        state <= FILL;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_row_max_sub.sv
// tb/tb_row_max_sub.sv - scoreboard bench for row_max_sub
module tb_row_max_sub;

  localparam int D_W     = 8;
  localparam int MAX_LEN = 8;
  localparam int ADDR_W  = 3;
`ifdef ROW_MAX_SUB_SAT_EN
  localparam int OUT_W = 8;
`else
  localparam int OUT_W = 9;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [D_W-1:0]   in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [D_W-1:0]   row_max;
  logic             err_overflow;

  int errors = 0;
  int checks = 0;
  int exp_d_q[$];
  bit exp_l_q[$];
  bit toggle_mode = 1'b0;

  always #5 clk = ~clk;

  row_max_sub #(.D_W(D_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .row_max     (row_max),
    .err_overflow(err_overflow)
  );

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int v, input bit last);
    exp_d_q.push_back(v);
    exp_l_q.push_back(last);
  endtask

  task automatic send(input int d, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d[D_W-1:0];
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_d_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_d_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted output, and checks that a
  // stalled output holds its value.
  initial begin : monitor
    bit prev_stall;
    logic [OUT_W-1:0] prev_d;
    logic prev_l;
    int ed;
    bit el;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check_val("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_l, prev_d});
        if (out_valid && out_ready) begin
          if (exp_d_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0d expected none", $signed(out_data));
          end else begin
            ed = exp_d_q.pop_front();
            el = exp_l_q.pop_front();
            check_val("out_data", $signed(out_data), ed);
            check_val("out_last", out_last, el);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_row_max", row_max, 0);
    check_val("rst_err", err_overflow, 0);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Row 3,-5,7,1
    push(-4, 0); push(-12, 0); push(0, 0); push(-6, 1);
    send(3, 0); send(-5, 0); send(7, 0); send(1, 1);
    wait_idle();
    check_val("t1_row_max", $signed(row_max), 7);
    check_val("t1_err", err_overflow, 0);
    check_val("t1_in_ready", in_ready, 1);

    // Single element row
    push(0, 1);
    send(-8, 1);
    wait_idle();
    check_val("t2_row_max", $signed(row_max), -8);
    check_val("t2_in_ready", in_ready, 1);

    // Extreme difference
    push(0, 0);
`ifdef ROW_MAX_SUB_SAT_EN
    push(-128, 1);
`else
    push(-255, 1);
`endif
    send(127, 0); send(-128, 1);
    wait_idle();
    check_val("t3_row_max", $signed(row_max), 127);

    // 0..7 with out_ready toggling
    toggle_mode = 1'b1;
    for (int i = 0; i < 8; i++) push(i - 7, i == 7);
    for (int i = 0; i < 8; i++) send(i, i == 7);
    wait_idle();
    toggle_mode = 1'b0;
    check_val("t4_row_max", $signed(row_max), 7);
    check_val("t4_err", err_overflow, 0);

    // Overflow: MAX_LEN beats without in_last, extra beat refused
    for (int i = 1; i <= 8; i++) push(i - 8, i == 8);
    for (int i = 1; i <= 8; i++) send(i, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd9;
    in_last  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("t5_in_ready", in_ready, 0);
      check_val("t5_err", err_overflow, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    check_val("t5_row_max", $signed(row_max), 8);

    // Reset mid-fill
    send(4, 0); send(6, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("t6_out_valid", out_valid, 0);
    check_val("t6_out_data", out_data, 0);
    check_val("t6_row_max", row_max, 0);
    check_val("t6_err", err_overflow, 0);
    check_val("t6_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    push(0, 0); push(-3, 1);
    send(5, 0); send(2, 1);
    wait_idle();
    check_val("t6_row_max_after", $signed(row_max), 5);
    check_val("queue_empty", exp_d_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
